bcd_to_binary: RTL and testbench
================================

// Module: bcd_to_binary
// PURPOSE
//  Multi-cycle BCD-to-binary converter. It is the inverse of the on-screen binary-to-BCD path.
//  It turns packed BCD digits into a plain binary value using reverse double-dabble:
//  shift right one bit per clock, then subtract 3 from every digit that is >= 8.
//  Used where decimal entries (angle, scale, menu values) must be converted back for datapath use.
// PARAMETERS
//  DIGITS  3   number of packed BCD digits on bcd_in (hundreds digit is the most significant)
//  BIN_W   10  binary result width; one shift per bit, so a conversion takes BIN_W shift cycles
// PORTS
//  clk      in   1           system clock; all logic is on posedge clk
//  rst      in   1           synchronous reset, active-high
//  start    in   1           single-cycle request; sampled only in IDLE
//  bcd_in   in   4*DIGITS    packed BCD; digit k is at [4k+3:4k]; sampled with start
//  busy     out  1           high from the cycle after start is accepted until done
//  done     out  1           single-cycle pulse; bin_out, err and ovf are valid in that cycle
//  bin_out  out  BIN_W       binary result; holds its value until the next done
//  err      out  1           an input digit was > 9; updated with done
//  ovf      out  1           value does not fit in BIN_W bits; updated with done
// BEHAVIOUR
//  Reset: rst=1 at a posedge gives state=IDLE and busy=done=err=ovf=0, bin_out=0,
//   shift register and counter cleared. Reset takes priority over everything,
//   including a conversion in flight; no done is produced for an aborted conversion.
//  Internal shift register SR is {bcd(4*DIGITS), bin(BIN_W)}; counter cnt is $clog2(BIN_W+1) bits.
//  States:
//   IDLE:  start=1 at edge T0 loads SR={bcd_in,0}, cnt=0, latches digit_bad, goes to SHIFT.
//          digit_bad = OR over all digits of (digit > 9).
//          busy=1 from T0. If start=0, stay in IDLE.
//   SHIFT: each edge does SR = SR >> 1 (zero enters the MSB), then for every BCD digit field
//          of the shifted value, if digit >= 8 then digit = digit - 3 (4-bit, no carry out).
//          cnt increments. At the edge where cnt reaches BIN_W (edge T0+BIN_W), go to DONE.
//   DONE:  at edge T0+BIN_W+1: bin_out = digit_bad ? 0 : SR[BIN_W-1:0];
//          err = digit_bad; ovf = !digit_bad && (SR BCD field != 0).
//          done=1 and busy=0 for exactly that cycle; then return to IDLE.
//  Latency: start seen at edge T0 gives done high in the cycle after edge T0+BIN_W+1.
//   That is 11 clocks for the default BIN_W=10.
//  start while busy (SHIFT or DONE) is ignored: no queueing, bcd_in is not resampled.
//  Back-to-back: a start in the cycle after done (state IDLE) is accepted. Max rate is one
//   conversion per BIN_W+2 clocks.
//  bcd_in may change freely after the start edge; the loaded copy is used.
//  Arithmetic: digit corrections are independent per field and are applied after the shift
//   in the same cycle. No digit borrows across fields.
//  With defaults (999 < 1024), ovf can never assert. It matters only if BIN_W is undersized.
//  Invalid digits (0xA-0xF): the conversion still runs its full length so latency is fixed;
//   the result is forced to 0 and err=1.
// TESTING
//  1) bcd_in=12'h999, start 1 cycle -> done 11 clocks later, bin_out=10'd999 (0x3E7), err=0, ovf=0.
//  2) bcd_in=12'h000 -> bin_out=0; then 12'h001 -> 1; 12'h100 -> 100; 12'h512 -> 512.
//  3) bcd_in=12'h0A5 -> done at the same latency, bin_out=0, err=1; the previous result is replaced.
//  4) start pulsed again 3 cycles into a conversion with a different bcd_in -> ignored,
//     one done only, result belongs to the first input.
//  5) rst=1 at the 5th shift cycle -> next cycle busy=0, done never pulses, bin_out=0;
//     a fresh start then converts normally.
//  6) BIN_W=8 override, bcd_in=12'h300 -> ovf=1; 12'h255 -> bin_out=8'd255, ovf=0.
//     Plus an exhaustive sweep of 0..999 against the reference value.

Source files
------------

// File: rtl/bcd_to_binary_if.sv
// bcd_to_binary_if: request/result bundle for the BCD-to-binary converter.
//   start    requester -> converter  single-cycle conversion request
//   bcd_in   requester -> converter  packed BCD digits, digit k at [4k+3:4k]
//   busy     converter -> requester  conversion in progress
//   done     converter -> requester  one-cycle pulse; bin_out/err/ovf valid
//   bin_out  converter -> requester  binary result, held until the next done
//   err      converter -> requester  an input digit was > 9
//   ovf      converter -> requester  value did not fit in BIN_W bits
interface bcd_to_binary_if #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic [BIN_W-1:0]      bin_out;
    logic                  err;
    logic                  ovf;

    modport master (output start, bcd_in, input busy, done, bin_out, err, ovf);
    modport slave  (input start, bcd_in, output busy, done, bin_out, err, ovf);
endinterface

// File: rtl/bcd_to_binary.sv
// bcd_to_binary: multi-cycle BCD-to-binary converter (reverse double-dabble).
// A shift register {bcd, bin} is shifted right once per clock for BIN_W clocks;
// after each shift every BCD digit >= 8 has 3 subtracted. What is left in the
// bin field is the binary value; anything left in the BCD field means overflow.
//   clk  system clock (posedge)
//   rst  synchronous reset, active-high, highest priority
//   io   bcd_to_binary_if.slave: start/bcd_in in; busy/done/bin_out/err/ovf out
// Latency: start accepted at edge T0 -> done high in the cycle after T0+BIN_W+1.
module bcd_to_binary #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic             clk,
    input  logic             rst,
    bcd_to_binary_if.slave   io
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state_q, state_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bad_q, bad_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [BIN_W-1:0]  bin_q, bin_d;
    logic              err_q, err_d;
    logic              ovf_q, ovf_d;

    logic [SR_W-1:0]   sr_step;
    logic              digit_bad;
    logic [CNT_W-1:0]  cnt_inc;

    // One reverse double-dabble step: shift, then fix each digit on its own.
    // A digit >= 8 after the shift received a "10" worth of weight from the
    // digit above, which is 8 in binary; subtracting 3 maps it back to 5.
    always_comb begin
        sr_step = sr_q >> 1;
        for (int k = 0; k < DIGITS; k++) begin
            if (sr_step[BIN_W + 4*k +: 4] >= 4'd8)
                sr_step[BIN_W + 4*k +: 4] = sr_step[BIN_W + 4*k +: 4] - 4'd3;
        end
    end

    always_comb begin
        digit_bad = 1'b0;
        for (int k = 0; k < DIGITS; k++)
            if (io.bcd_in[4*k +: 4] > 4'd9) digit_bad = 1'b1;
    end

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        bad_d   = bad_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bin_d   = bin_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (io.start) begin
                    sr_d    = {io.bcd_in, {BIN_W{1'b0}}};
                    cnt_d   = '0;
                    bad_d   = digit_bad;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_d  = sr_step;
                cnt_d = cnt_inc;
                if (cnt_inc == CNT_LAST) state_d = DONE;
            end
            DONE: begin
                // Invalid digits still run the full length so latency is fixed.
                bin_d   = bad_q ? '0 : sr_q[BIN_W-1:0];
                err_d   = bad_q;
                ovf_d   = !bad_q && (sr_q[SR_W-1:BIN_W] != '0);
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            bad_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bin_q   <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            bad_q   <= bad_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    assign io.busy    = busy_q;
    assign io.done    = done_q;
    assign io.bin_out = bin_q;
    assign io.err     = err_q;
    assign io.ovf     = ovf_q;
endmodule

// File: tb/tb_bcd_to_binary.sv
// Bench for bcd_to_binary: table of vectors plus a decimal sweep driven through
// a scoreboard queue, hand sequences for ignored start, mid-run reset, and a
// BIN_W=8 instance for overflow.
module tb_bcd_to_binary;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bcd_to_binary_if #(.DIGITS(3), .BIN_W(10)) bif ();
    bcd_to_binary_if #(.DIGITS(3), .BIN_W(8))  bif8 ();

    bcd_to_binary #(.DIGITS(3), .BIN_W(10)) u_dut  (.clk(clk), .rst(rst), .io(bif));
    bcd_to_binary #(.DIGITS(3), .BIN_W(8))  u_dut8 (.clk(clk), .rst(rst), .io(bif8));

    typedef struct {
        logic [9:0] bin;
        logic       err;
        logic       ovf;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [11:0] bcd;
        logic [9:0]  bin;
        logic        err;
    } vec_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every done pops one expectation, including its cycle.
    always @(negedge clk) begin
        if (bif.done === 1'b1) begin
            exp_t e;
            done_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("bin_out", 32'(bif.bin_out), 32'(e.bin));
                chk("err", 32'(bif.err), 32'(e.err));
                chk("ovf", 32'(bif.ovf), 32'(e.ovf));
                chk("latency", 32'(cyc), 32'(e.cyc));
                chk("busy_at_done", 32'(bif.busy), 32'd0);
            end
        end
    end

    // Drive one start pulse, called right after a posedge.
    task automatic pulse(input logic [11:0] bcd);
        bif.bcd_in = bcd;
        bif.start  = 1'b1;
        @(posedge clk); #1;
        bif.start  = 1'b0;
        bif.bcd_in = 12'hFFF;   // loaded copy must be used
    endtask

    task automatic wait_drain(input string name);
        int i;
        for (i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (exp_q.size() == 0) break;
        end
        if (i == 40) begin
            chk({name, "_timeout"}, 32'd1, 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic convert(input logic [11:0] bcd, input logic [9:0] bin, input logic err);
        exp_t e;
        @(posedge clk); #1;
        e.bin = bin; e.err = err; e.ovf = 1'b0; e.cyc = cyc + 12;
        exp_q.push_back(e);
        pulse(bcd);
        wait_drain("convert");
    endtask

    task automatic conv8(input logic [11:0] bcd, input logic [7:0] bin, input logic ovf);
        int i;
        @(posedge clk); #1;
        bif8.bcd_in = bcd;
        bif8.start  = 1'b1;
        @(posedge clk); #1;
        bif8.start  = 1'b0;
        for (i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bif8.done === 1'b1) break;
        end
        if (i == 30) chk("w8_timeout", 32'd1, 32'd0);
        else begin
            chk("w8_bin_out", 32'(bif8.bin_out), 32'(bin));
            chk("w8_ovf", 32'(bif8.ovf), 32'(ovf));
            chk("w8_err", 32'(bif8.err), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        int   dc;
        exp_t e;

        vecs[0] = '{12'h999, 10'd999, 1'b0};
        vecs[1] = '{12'h000, 10'd0,   1'b0};
        vecs[2] = '{12'h001, 10'd1,   1'b0};
        vecs[3] = '{12'h100, 10'd100, 1'b0};
        vecs[4] = '{12'h512, 10'd512, 1'b0};
        vecs[5] = '{12'h0A5, 10'd0,   1'b1};
        vecs[6] = '{12'h090, 10'd90,  1'b0};
        vecs[7] = '{12'hF00, 10'd0,   1'b1};
        vecs[8] = '{12'h099, 10'd99,  1'b0};
        vecs[9] = '{12'h808, 10'd808, 1'b0};

        bif.start = 1'b0;  bif.bcd_in = 12'h000;
        bif8.start = 1'b0; bif8.bcd_in = 12'h000;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bif.busy), 32'd0);
        chk("rst_done", 32'(bif.done), 32'd0);
        chk("rst_bin",  32'(bif.bin_out), 32'd0);
        chk("rst_err",  32'(bif.err), 32'd0);
        chk("rst_ovf",  32'(bif.ovf), 32'd0);
        rst = 1'b0;

        // busy rises right after the start edge and stays up mid-run
        @(posedge clk); #1;
        e = '{bin: 10'd999, err: 1'b0, ovf: 1'b0, cyc: cyc + 12};
        exp_q.push_back(e);
        pulse(12'h999);
        chk("busy_after_start", 32'(bif.busy), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("busy_mid", 32'(bif.busy), 32'd1);
        wait_drain("first");

        for (int i = 0; i < 10; i++)
            convert(vecs[i].bcd, vecs[i].bin, vecs[i].err);

        // result holds after done
        repeat (4) @(posedge clk);
        #1;
        chk("hold_bin", 32'(bif.bin_out), 32'd808);

        // start while busy is ignored
        dc = done_cnt;
        @(posedge clk); #1;
        e = '{bin: 10'd421, err: 1'b0, ovf: 1'b0, cyc: cyc + 12};
        exp_q.push_back(e);
        pulse(12'h421);
        repeat (2) @(posedge clk);
        #1;
        pulse(12'h123);
        wait_drain("ignore");
        repeat (20) @(posedge clk);
        #1;
        chk("ignore_done_count", 32'(done_cnt - dc), 32'd1);

        // reset in the 5th shift cycle aborts without a done
        dc = done_cnt;
        @(posedge clk); #1;
        pulse(12'h777);         // now just after edge T0
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 32'(bif.busy), 32'd0);
        chk("abort_bin",  32'(bif.bin_out), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_cnt - dc), 32'd0);
        convert(12'h321, 10'd321, 1'b0);

        // exhaustive decimal sweep
        for (int d = 0; d < 1000; d++) begin
            logic [11:0] b;
            b = {4'(d / 100), 4'((d / 10) % 10), 4'(d % 10)};
            convert(b, 10'(d), 1'b0);
        end

        // undersized result width
        conv8(12'h300, 8'd44, 1'b1);
        conv8(12'h255, 8'd255, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
